multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state changes on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-low.
REQ-003 instr_op_i  in  6  opcode from instruction register; stable outside FETCH.
REQ-004 zero_i  in  1  ALU zero flag.
REQ-005 mem_ready_i  in  1  memory completion; meaningful only while mem_req_o=1.
REQ-006 mem_req_o  out  1  memory access request.
REQ-007 mem_we_o  out  1  write enable, valid with mem_req_o.
REQ-008 IorD_o  out  1  address select: 0=PC, 1=ALUOut.
REQ-009 IRWrite_o  out  1  instruction register load.
REQ-010 PCWrite_o  out  1  PC load.
REQ-011 PCSrc_o  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 RegWrite_o  out  1  register file write.
REQ-013 RegDst_o  out  1  destination: 1=rd, 0=rt.
REQ-014 MemtoReg_o  out  1  write-back source: 1=MDR, 0=ALUOut.
REQ-015 ALUSrcA_o  out  1  ALU A: 0=PC, 1=rs.
REQ-016 ALUSrcB_o  out  2  ALU B: 00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-017 ALU_op_o  out  3  000=add, 001=sub, 010=R-type by funct, 011=slt.
REQ-018 illegal_o  out  1  one-cycle pulse on unsupported opcode.
REQ-019 retire_o  out  1  one-cycle pulse when an instruction completes.
REQ-020 instr_cnt_o  out  32  retired-instruction count, wraps modulo 2^32.
REQ-021 state_o  out  4  current state encoding, for debug.

Function
REQ-022 Opcodes SHALL be: R 000000, addi 001000, slti 001010, beq 000100, lw 100011, sw 101011, j 000010; all others illegal.
REQ-023 States/encodings SHALL be FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, EXEC_I 9, WB_I 10, JUMP 11; 12-15 SHALL go to FETCH.
REQ-024 Outputs SHALL be combinational from state (Moore), except IRWrite_o/PCWrite_o/retire_o as stated; unlisted outputs 0.
REQ-025 FETCH: mem_req=1, IorD=0, SrcA=0, SrcB=01, add, PCSrc=00; stay until mem_ready_i=1; in that cycle IRWrite=1, PCWrite=1, next DECODE.
REQ-026 DECODE: SrcA=0, SrcB=11, add; next R->EXEC_R, addi/slti->EXEC_I, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, illegal->FETCH with illegal_o=1 that cycle.
REQ-027 MEM_ADDR: SrcA=1, SrcB=10, add; next MEM_RD (lw) or MEM_WR (sw).
REQ-028 MEM_RD: mem_req=1, IorD=1; hold until mem_ready_i=1, then MEM_WB.
REQ-029 MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, retire; next FETCH.
REQ-030 MEM_WR: mem_req=1, mem_we=1, IorD=1; hold until mem_ready_i=1; retire in that cycle; next FETCH.
REQ-031 EXEC_R: SrcA=1, SrcB=00, ALU_op=010; next WB_R. WB_R: RegWrite=1, RegDst=1, retire; next FETCH.
REQ-032 EXEC_I: SrcA=1, SrcB=10, ALU_op=000 (addi) or 011 (slti); next WB_I. WB_I: RegWrite=1, RegDst=0, retire; next FETCH.
REQ-033 BRANCH: SrcA=1, SrcB=00, sub, PCSrc=01, PCWrite=zero_i, retire; next FETCH.
REQ-034 JUMP: PCSrc=10, PCWrite=1, retire; next FETCH.
REQ-035 mem_req_o SHALL stay high every cycle until mem_ready_i sampled 1; mem_ready_i while mem_req_o=0 SHALL be ignored.
REQ-036 instr_cnt_o SHALL increment by 1 on the edge ending each retire_o cycle; 0xFFFFFFFF wraps to 0; illegal opcodes not counted.
REQ-037 Minimum latency with zero-wait memory: R/addi/slti/lw 4-5 cycles (lw 5), sw/beq/j 4, 3, 3 cycles respectively.

Reset
REQ-038 rst_i=0 SHALL immediately force state FETCH, instr_cnt_o=0, illegal_o=0, retire_o=0, and drop any in-flight request until release.
REQ-039 First cycle after release SHALL be FETCH with mem_req_o=1, IorD_o=0.

Structure
REQ-040 Package multicycle_ctrl_pkg SHALL hold state encodings, opcode constants, ALU_op, ALUSrcB and PCSrc codes.
REQ-041 No sub-module; one state register, one next-state block, one output decode block, one counter.

Verification
REQ-042 add (op 000000), mem_ready_i=1 always -> states 0,1,6,7; RegWrite=1,RegDst=1 in WB_R; instr_cnt 0->1.
REQ-043 lw, mem_ready_i delayed 3 cycles in FETCH and MEM_RD -> mem_req held 3 cycles each; MEM_WB MemtoReg=1; retire once.
REQ-044 beq with zero_i=0 then zero_i=1 -> PCWrite 0 then 1 in BRANCH, PCSrc=01; both retire.
REQ-045 opcode 111111 -> illegal_o pulse in DECODE, back to FETCH, instr_cnt unchanged.
REQ-046 rst_i low during MEM_WR with mem_req high -> mem_req 0 same cycle, state 0, instr_cnt 0.
REQ-047 preload count 0xFFFFFFFF via forced retires, j -> instr_cnt_o wraps to 0, PCSrc=10.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and
// the datapath select codes it drives.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_EXEC_I   = 4'd9,
    ST_WB_I     = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_SLT   = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_J: is_legal_op = 1'b1;
      default:                                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a MIPS-like multicycle datapath, with a
// retired-instruction counter. Memory handshakes hold the request until
// mem_ready_i is seen.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        IorD_o,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic [1:0]  PCSrc_o,
  output logic        RegWrite_o,
  output logic        RegDst_o,
  output logic        MemtoReg_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [2:0]  ALU_op_o,
  output logic        illegal_o,
  output logic        retire_o,
  output logic [31:0] instr_cnt_o,
  output logic [3:0]  state_o
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] instr_cnt_q;

  // Raw strobes before the reset gate.
  logic mem_req_d;
  logic mem_we_d;
  logic ir_write_d;
  logic pc_write_d;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection.
  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        case (instr_op_i)
          OP_R:           state_d = ST_EXEC_R;
          OP_ADDI,
          OP_SLTI:        state_d = ST_EXEC_I;
          OP_LW,
          OP_SW:          state_d = ST_MEM_ADDR;
          OP_BEQ:         state_d = ST_BRANCH;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_d = (instr_op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready_i) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_MEM_WB,
      ST_WB_R,
      ST_WB_I,
      ST_BRANCH,
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // Output decode: Moore outputs from state, plus the few handshake- or
  // flag-qualified strobes.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    ir_write_d = 1'b0;
    pc_write_d = 1'b0;
    IorD_o     = 1'b0;
    PCSrc_o    = PC_ALU;
    RegWrite_o = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = SRCB_RT;
    ALU_op_o   = ALU_ADD;
    illegal_o  = 1'b0;
    retire_o   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_d  = 1'b1;
        ALUSrcB_o  = SRCB_FOUR;
        ir_write_d = mem_ready_i;
        pc_write_d = mem_ready_i;
      end
      ST_DECODE: begin
        ALUSrcB_o = SRCB_IMM_SH2;
        illegal_o = !is_legal_op(instr_op_i);
      end
      ST_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_req_d = 1'b1;
        IorD_o    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        retire_o   = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        IorD_o    = 1'b1;
        retire_o  = mem_ready_i;
      end
      ST_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_FUNCT;
      end
      ST_WB_R: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        retire_o   = 1'b1;
      end
      ST_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALU_op_o  = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      ST_WB_I: begin
        RegWrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALU_op_o   = ALU_SUB;
        PCSrc_o    = PC_ALUOUT;
        pc_write_d = zero_i;
        retire_o   = 1'b1;
      end
      ST_JUMP: begin
        PCSrc_o    = PC_JUMP;
        pc_write_d = 1'b1;
        retire_o   = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is asserted the state already sits in FETCH, which would
  // otherwise raise a request; gating here drops it in the same cycle.
  assign mem_req_o = mem_req_d  & rst_i;
  assign mem_we_o  = mem_we_d   & rst_i;
  assign IRWrite_o = ir_write_d & rst_i;
  assign PCWrite_o = pc_write_d & rst_i;

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        instr_cnt_q <= '0;
    else if (retire_o) instr_cnt_q <= instr_cnt_q + 32'd1;
  end

  assign instr_cnt_o = instr_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks control outputs against hand-derived values.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        IorD_o;
  logic        IRWrite_o;
  logic        PCWrite_o;
  logic [1:0]  PCSrc_o;
  logic        RegWrite_o;
  logic        RegDst_o;
  logic        MemtoReg_o;
  logic        ALUSrcA_o;
  logic [1:0]  ALUSrcB_o;
  logic [2:0]  ALU_op_o;
  logic        illegal_o;
  logic        retire_o;
  logic [31:0] instr_cnt_o;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_op_i  (instr_op_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .IorD_o      (IorD_o),
    .IRWrite_o   (IRWrite_o),
    .PCWrite_o   (PCWrite_o),
    .PCSrc_o     (PCSrc_o),
    .RegWrite_o  (RegWrite_o),
    .RegDst_o    (RegDst_o),
    .MemtoReg_o  (MemtoReg_o),
    .ALUSrcA_o   (ALUSrcA_o),
    .ALUSrcB_o   (ALUSrcB_o),
    .ALU_op_o    (ALU_op_o),
    .illegal_o   (illegal_o),
    .retire_o    (retire_o),
    .instr_cnt_o (instr_cnt_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b0;
    instr_op_i  = OP_R;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;
    #2;
    // Reset state: FETCH, request suppressed, nothing strobed.
    check("rst_state",   32'(state_o),     0);
    check("rst_mem_req", 32'(mem_req_o),   0);
    check("rst_irwrite", 32'(IRWrite_o),   0);
    check("rst_pcwrite", 32'(PCWrite_o),   0);
    check("rst_cnt",     instr_cnt_o,      0);
    check("rst_illegal", 32'(illegal_o),   0);
    check("rst_retire",  32'(retire_o),    0);

    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rel_state",   32'(state_o),   0);
    check("rel_mem_req", 32'(mem_req_o), 1);
    check("rel_iord",    32'(IorD_o),    0);

    // R-type add, zero-wait memory: 0,1,6,7.
    check("add_f_irw",   32'(IRWrite_o), 1);
    check("add_f_pcw",   32'(PCWrite_o), 1);
    check("add_f_srcb",  32'(ALUSrcB_o), 1);
    cycle();
    check("add_d_state", 32'(state_o),   1);
    check("add_d_srcb",  32'(ALUSrcB_o), 3);
    cycle();
    check("add_e_state", 32'(state_o),   6);
    check("add_e_aluop", 32'(ALU_op_o),  2);
    check("add_e_srca",  32'(ALUSrcA_o), 1);
    check("add_e_srcb",  32'(ALUSrcB_o), 0);
    cycle();
    check("add_w_state", 32'(state_o),    7);
    check("add_w_regw",  32'(RegWrite_o), 1);
    check("add_w_regdst",32'(RegDst_o),   1);
    check("add_w_retire",32'(retire_o),   1);
    check("add_w_cnt",   instr_cnt_o,     0);
    cycle();
    check("add_end_state", 32'(state_o), 0);
    check("add_end_cnt",   instr_cnt_o,  1);

    // lw with three wait cycles in FETCH and in MEM_RD.
    instr_op_i  = OP_LW;
    mem_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_f_state", 32'(state_o),   0);
      check("lw_f_req",   32'(mem_req_o), 1);
      check("lw_f_irw",   32'(IRWrite_o), 0);
      cycle();
    end
    mem_ready_i = 1'b1;
    #1;
    check("lw_f_irw_rdy", 32'(IRWrite_o), 1);
    cycle();
    mem_ready_i = 1'b0;
    #1;
    check("lw_d_state", 32'(state_o), 1);
    cycle();
    check("lw_a_state", 32'(state_o),   2);
    check("lw_a_srcb",  32'(ALUSrcB_o), 2);
    check("lw_a_req",   32'(mem_req_o), 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      check("lw_r_state", 32'(state_o),   3);
      check("lw_r_req",   32'(mem_req_o), 1);
      check("lw_r_iord",  32'(IorD_o),    1);
      check("lw_r_retire",32'(retire_o),  0);
      cycle();
    end
    mem_ready_i = 1'b1;
    #1;
    cycle();
    check("lw_wb_state", 32'(state_o),    4);
    check("lw_wb_m2r",   32'(MemtoReg_o), 1);
    check("lw_wb_regw",  32'(RegWrite_o), 1);
    check("lw_wb_regdst",32'(RegDst_o),   0);
    check("lw_wb_retire",32'(retire_o),   1);
    cycle();
    check("lw_end_state", 32'(state_o), 0);
    check("lw_end_cnt",   instr_cnt_o,  2);

    // beq not taken, then taken.
    instr_op_i = OP_BEQ;
    zero_i     = 1'b0;
    cycle();
    cycle();
    check("beq0_state", 32'(state_o),   8);
    check("beq0_pcw",   32'(PCWrite_o), 0);
    check("beq0_pcsrc", 32'(PCSrc_o),   1);
    check("beq0_aluop", 32'(ALU_op_o),  1);
    check("beq0_retire",32'(retire_o),  1);
    cycle();
    check("beq0_cnt", instr_cnt_o, 3);
    zero_i = 1'b1;
    cycle();
    cycle();
    check("beq1_state", 32'(state_o),   8);
    check("beq1_pcw",   32'(PCWrite_o), 1);
    check("beq1_pcsrc", 32'(PCSrc_o),   1);
    cycle();
    check("beq1_cnt", instr_cnt_o, 4);
    zero_i = 1'b0;

    // Illegal opcode: pulse in DECODE, no retire, count unchanged.
    instr_op_i = 6'b111111;
    cycle();
    check("ill_state",  32'(state_o),   1);
    check("ill_pulse",  32'(illegal_o), 1);
    check("ill_retire", 32'(retire_o),  0);
    cycle();
    check("ill_back",   32'(state_o),   0);
    check("ill_clear",  32'(illegal_o), 0);
    check("ill_cnt",    instr_cnt_o,    4);

    // slti: 0,1,9,10.
    instr_op_i = OP_SLTI;
    cycle();
    cycle();
    check("slti_e_state", 32'(state_o),  9);
    check("slti_e_aluop", 32'(ALU_op_o), 3);
    cycle();
    check("slti_w_state", 32'(state_o),    10);
    check("slti_w_regw",  32'(RegWrite_o), 1);
    check("slti_w_regdst",32'(RegDst_o),   0);
    cycle();
    check("slti_cnt", instr_cnt_o, 5);

    // sw with zero-wait memory: retires in MEM_WR.
    instr_op_i = OP_SW;
    cycle();
    cycle();
    cycle();
    check("sw_state",  32'(state_o),  5);
    check("sw_we",     32'(mem_we_o), 1);
    check("sw_retire", 32'(retire_o), 1);
    cycle();
    check("sw_cnt", instr_cnt_o, 6);

    // sw interrupted by reset while the write request is pending.
    cycle();
    cycle();
    mem_ready_i = 1'b0;
    #1;
    cycle();
    check("swr_state",  32'(state_o),   5);
    check("swr_req",    32'(mem_req_o), 1);
    check("swr_retire", 32'(retire_o),  0);
    cycle();
    #1;
    rst_i = 1'b0;
    #1;
    check("swr_rst_req",   32'(mem_req_o), 0);
    check("swr_rst_we",    32'(mem_we_o),  0);
    check("swr_rst_state", 32'(state_o),   0);
    check("swr_rst_cnt",   instr_cnt_o,    0);
    @(negedge clk_i);
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    instr_op_i  = OP_J;
    #1;
    check("swr_rel_req", 32'(mem_req_o), 1);

    // Counter wrap on a jump retire.
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    #1;
    check("wrap_preload", instr_cnt_o, 32'hFFFF_FFFF);
    cycle();
    cycle();
    check("j_state",  32'(state_o),   11);
    check("j_pcsrc",  32'(PCSrc_o),   2);
    check("j_pcw",    32'(PCWrite_o), 1);
    check("j_retire", 32'(retire_o),  1);
    cycle();
    check("wrap_cnt",   instr_cnt_o,  0);
    check("wrap_state", 32'(state_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
